// File: rtl/buzzer_melody_if.sv
// ---------------------------------------------------------------------------
// buzzer_melody_if
// Groups the request lines and buzzer outputs between the game logic and the
// melody sequencer.
//   ev        : NUM_CH request lines; a rising edge requests melody i
//   buzzer    : square-wave drive to the buzzer pin
//   busy      : high while a melody is playing
//   active_ch : channel being played, 0 when idle
//   mute      : forces buzzer low (only when BUZZER_MUTE_EN is defined)
// Modports: master = game logic side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface buzzer_melody_if #(
    parameter int unsigned NUM_CH = 4
);
    logic [NUM_CH-1:0] ev;
    logic              buzzer;
    logic              busy;
    logic [2:0]        active_ch;
`ifdef BUZZER_MUTE_EN
    logic              mute;

    modport master (output ev, output mute, input buzzer, input busy, input active_ch);
    modport slave  (input ev, input mute, output buzzer, output busy, output active_ch);
`else
    modport master (output ev, input buzzer, input busy, input active_ch);
    modport slave  (input ev, output buzzer, output busy, output active_ch);
`endif
endinterface

// File: rtl/buzzer_melody.sv
// ---------------------------------------------------------------------------
// buzzer_melody
// Event-driven buzzer sequencer: a rising edge on a request line plays that
// channel's fixed 4-step melody as a 50 % square wave. Lower channel index
// has priority and pre-empts a melody in progress; other requests queue.
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-low reset
//   bus  : buzzer_melody_if.slave (ev in; buzzer, busy, active_ch out;
//          mute in when BUZZER_MUTE_EN is defined)
// Optional feature macro: BUZZER_MUTE_EN (adds a mute input that silences
// the pin without disturbing sequencing or waveform phase).
// ---------------------------------------------------------------------------
module buzzer_melody #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned STEP_MS  = 125,
    parameter int unsigned GAP_MS   = 20
) (
    input  logic           clk,
    input  logic           rst,
    buzzer_melody_if.slave bus
);
    localparam int unsigned UNIT_CYC = (CLK_FREQ / 1000) * STEP_MS;
    localparam int unsigned GAP_CYC  = (CLK_FREQ / 1000) * GAP_MS;
    localparam int unsigned HALF_DO  = CLK_FREQ / (2 * 262);
    localparam int unsigned TMAX     = (2 * UNIT_CYC > GAP_CYC) ? 2 * UNIT_CYC : GAP_CYC;
    localparam int unsigned TW       = $clog2(TMAX + 1);
    localparam int unsigned HW       = $clog2(HALF_DO + 1);

    typedef enum logic [1:0] {IDLE, TONE, GAP} state_e;

    // Half period in cycles for each note code; REST has no waveform.
    function automatic logic [HW-1:0] half_of(input logic [2:0] note);
        case (note)
            3'd1:    half_of = HW'(CLK_FREQ / (2 * 262));
            3'd2:    half_of = HW'(CLK_FREQ / (2 * 294));
            3'd3:    half_of = HW'(CLK_FREQ / (2 * 330));
            3'd4:    half_of = HW'(CLK_FREQ / (2 * 349));
            3'd5:    half_of = HW'(CLK_FREQ / (2 * 392));
            3'd6:    half_of = HW'(CLK_FREQ / (2 * 440));
            3'd7:    half_of = HW'(CLK_FREQ / (2 * 494));
            default: half_of = '0;
        endcase
    endfunction

    // Melody ROM, entry = {dur_units, note}.
    function automatic logic [4:0] rom(input logic [1:0] mel, input logic [1:0] stp);
        case ({mel, stp})
            4'h0:    rom = {2'd1, 3'd6};
            4'h1:    rom = {2'd1, 3'd3};
            4'h2:    rom = {2'd1, 3'd6};
            4'h3:    rom = {2'd1, 3'd3};
            4'h4:    rom = {2'd1, 3'd1};
            4'h5:    rom = {2'd1, 3'd3};
            4'h6:    rom = {2'd1, 3'd5};
            4'h7:    rom = {2'd2, 3'd7};
            4'h8:    rom = {2'd2, 3'd5};
            4'h9:    rom = {2'd1, 3'd4};
            4'hA:    rom = {2'd1, 3'd3};
            4'hB:    rom = {2'd2, 3'd2};
            4'hC:    rom = {2'd1, 3'd3};
            4'hD:    rom = {2'd1, 3'd0};
            4'hE:    rom = {2'd1, 3'd3};
            default: rom = {2'd1, 3'd0};
        endcase
    endfunction

    // Lowest set index of a request vector (0 when empty).
    function automatic logic [2:0] lowest(input logic [NUM_CH-1:0] v);
        lowest = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (v[i]) lowest = 3'(i);
        end
    endfunction

    state_e            state_q, state_d;
    logic [NUM_CH-1:0] ev_q, ev_prev_q;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] rise, pend_clr;
    logic [2:0]        ch_q, ch_d, low;
    logic [1:0]        step_q, step_d;
    logic [HW-1:0]     tcnt_q, tcnt_d, half;
    logic [TW-1:0]     time_q, time_d, tone_last;
    logic              tone_q, tone_d;
    logic              buz_q, buz_d;
    logic              busy_q, busy_d;
    logic [4:0]        entry;
    logic              take;

    // Next-state: request arbitration, step timing and tone generation.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        step_d   = step_q;
        tcnt_d   = tcnt_q;
        time_d   = time_q;
        tone_d   = tone_q;
        busy_d   = busy_q;
        pend_clr = '0;

        rise      = ev_q & ~ev_prev_q;
        low       = lowest(pend_q);
        entry     = rom(ch_q[1:0], step_q);
        half      = half_of(entry[2:0]);
        tone_last = (entry[4:3] == 2'd2) ? TW'(2 * UNIT_CYC - 1) : TW'(UNIT_CYC - 1);
        // Idle starts any request; while playing only a higher priority one wins.
        take      = (|pend_q) && ((state_q == IDLE) || (low < ch_q));

        if (take) begin
            state_d  = TONE;
            ch_d     = low;
            step_d   = '0;
            tcnt_d   = '0;
            time_d   = '0;
            tone_d   = 1'b0;
            busy_d   = 1'b1;
            pend_clr = NUM_CH'(1) << low;
        end else begin
            case (state_q)
                TONE: begin
                    if (time_q == tone_last) begin
                        state_d = GAP;
                        time_d  = '0;
                        tcnt_d  = '0;
                        tone_d  = 1'b0;
                    end else begin
                        time_d = time_q + TW'(1);
                        if (entry[2:0] != 3'd0) begin
                            if (tcnt_q == half - HW'(1)) begin
                                tcnt_d = '0;
                                tone_d = ~tone_q;
                            end else begin
                                tcnt_d = tcnt_q + HW'(1);
                            end
                        end
                    end
                end
                GAP: begin
                    if (time_q == TW'(GAP_CYC - 1)) begin
                        time_d = '0;
                        tcnt_d = '0;
                        tone_d = 1'b0;
                        if (step_q == 2'd3) begin
                            state_d = IDLE;
                            step_d  = '0;
                            // Queued work keeps busy up across the single idle cycle.
                            busy_d  = |(pend_q | rise);
                            ch_d    = busy_d ? ch_q : 3'd0;
                        end else begin
                            state_d = TONE;
                            step_d  = step_q + 2'd1;
                        end
                    end else begin
                        time_d = time_q + TW'(1);
                    end
                end
                default: ;
            endcase
        end

        // A fresh edge on the channel being taken stays pending.
        pend_d = (pend_q & ~pend_clr) | rise;
`ifdef BUZZER_MUTE_EN
        buz_d  = tone_d & ~bus.mute;
`else
        buz_d  = tone_d;
`endif
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            ev_q      <= '0;
            ev_prev_q <= '0;
            pend_q    <= '0;
            ch_q      <= '0;
            step_q    <= '0;
            tcnt_q    <= '0;
            time_q    <= '0;
            tone_q    <= 1'b0;
            buz_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ev_q      <= bus.ev;
            ev_prev_q <= ev_q;
            pend_q    <= pend_d;
            ch_q      <= ch_d;
            step_q    <= step_d;
            tcnt_q    <= tcnt_d;
            time_q    <= time_d;
            tone_q    <= tone_d;
            buz_q     <= buz_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.buzzer    = buz_q;
    assign bus.busy      = busy_q;
    assign bus.active_ch = ch_q;
endmodule

// File: tb/tb_buzzer_melody.sv
// ---------------------------------------------------------------------------
// tb_buzzer_melody
// Self-checking bench for buzzer_melody. A reference model expresses the
// expected outputs as a function of the melody start edge and the offset
// into the melody; directed checks confirm the key latencies and lengths.
// Honours BUZZER_MUTE_EN when defined.
// ---------------------------------------------------------------------------
module tb_buzzer_melody;
    localparam int unsigned CLK_FREQ = 1_000_000;
    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned STEP_MS  = 2;
    localparam int unsigned GAP_MS   = 1;
    localparam int UNIT = int'((CLK_FREQ / 1000) * STEP_MS);
    localparam int GAPC = int'((CLK_FREQ / 1000) * GAP_MS);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [NUM_CH-1:0] ev_cur = '0;
`ifdef BUZZER_MUTE_EN
    logic mute_cur = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int n = 0;

    buzzer_melody_if #(.NUM_CH(NUM_CH)) bus ();

    assign bus.ev = ev_cur;
`ifdef BUZZER_MUTE_EN
    assign bus.mute = mute_cur;
`endif

    buzzer_melody #(
        .CLK_FREQ (CLK_FREQ),
        .NUM_CH   (NUM_CH),
        .STEP_MS  (STEP_MS),
        .GAP_MS   (GAP_MS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Melody tables straight from the note/units listing.
    int note_tab [4][4] = '{'{6, 3, 6, 3}, '{1, 3, 5, 7}, '{5, 4, 3, 2}, '{3, 0, 3, 0}};
    int dur_tab  [4][4] = '{'{1, 1, 1, 1}, '{1, 1, 1, 2}, '{2, 1, 1, 2}, '{1, 1, 1, 1}};
    int freq_tab [8]    = '{0, 262, 294, 330, 349, 392, 440, 494};

    function automatic int melody_len(input int c);
        int len = 0;
        for (int s = 0; s < 4; s++) len += dur_tab[c % 4][s] * UNIT + GAPC;
        return len;
    endfunction

    // Expected pin level at a given offset from melody start.
    function automatic bit tone_at(input int c, input int off);
        int base = 0;
        for (int s = 0; s < 4; s++) begin
            int len  = dur_tab[c % 4][s] * UNIT;
            int note = note_tab[c % 4][s];
            if (off < base + len) begin
                if (note == 0) return 1'b0;
                return ((off - base) / (int'(CLK_FREQ) / (2 * freq_tab[note]))) % 2 == 1;
            end
            if (off < base + len + GAPC) return 1'b0;
            base += len + GAPC;
        end
        return 1'b0;
    endfunction

    function automatic int lowest_set(input logic [NUM_CH-1:0] v);
        for (int i = 0; i < int'(NUM_CH); i++) if (v[i]) return i;
        return -1;
    endfunction

    // Reference model state
    logic [NUM_CH-1:0] m_pend = '0;
    logic [NUM_CH-1:0] evs1 = '0;
    logic [NUM_CH-1:0] evs2 = '0;
    bit m_play = 1'b0;
    bit m_hold = 1'b0;
    int m_ch = 0;
    int m_start = 0;
    bit exp_buz, exp_busy;
    int exp_ch;

    // Monitor timestamps (edge numbers)
    bit prev_busy = 1'b0;
    logic [2:0] prev_ch = '0;
    int t_rise = -1;
    int t_fall = -1;
    int t_buz = -1;
    int t_act [8] = '{-1, -1, -1, -1, -1, -1, -1, -1};

    task automatic model_edge();
        logic [NUM_CH-1:0] rise;
        logic [NUM_CH-1:0] taken;
        int lp;
        bit mt;
        if (!rst) begin
            m_pend = '0;
            evs1   = '0;
            evs2   = '0;
            m_play = 1'b0;
            m_hold = 1'b0;
            m_ch   = 0;
        end else begin
            rise  = evs1 & ~evs2;
            taken = '0;
            lp    = lowest_set(m_pend);
            if (m_play) begin
                if (lp >= 0 && lp < m_ch) begin
                    m_ch = lp; m_start = n; taken[lp] = 1'b1;
                end else if (n - m_start == melody_len(m_ch)) begin
                    m_play = 1'b0;
                    m_hold = ((m_pend | rise) != '0);
                end
            end else begin
                m_hold = 1'b0;
                if (lp >= 0) begin
                    m_play = 1'b1; m_ch = lp; m_start = n; taken[lp] = 1'b1;
                end
            end
            m_pend = (m_pend & ~taken) | rise;
            evs2 = evs1;
            evs1 = ev_cur;
        end
`ifdef BUZZER_MUTE_EN
        mt = mute_cur;
`else
        mt = 1'b0;
`endif
        if (m_play) begin
            exp_busy = 1'b1; exp_ch = m_ch; exp_buz = tone_at(m_ch, n - m_start) & ~mt;
        end else if (m_hold) begin
            exp_busy = 1'b1; exp_ch = m_ch; exp_buz = 1'b0;
        end else begin
            exp_busy = 1'b0; exp_ch = 0; exp_buz = 1'b0;
        end
    endtask

    task automatic check_int(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One clock edge: advance model, then sample 1 time unit later.
    task automatic tick();
        logic [4:0] obs;
        logic [4:0] expv;
        @(posedge clk);
        n++;
        model_edge();
        #1;
        obs  = {bus.buzzer, bus.busy, bus.active_ch};
        expv = {exp_buz, exp_busy, 3'(exp_ch)};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL cycle %0d: observed buz/busy/ch=%b/%b/%0d expected %b/%b/%0d",
                   n, obs[4], obs[3], obs[2:0], expv[4], expv[3], expv[2:0]);
        end
        if (bus.busy === 1'b1 && !prev_busy) t_rise = n;
        if (bus.busy === 1'b0 && prev_busy) t_fall = n;
        prev_busy = (bus.busy === 1'b1);
        if (bus.buzzer === 1'b1 && t_buz < t_rise) t_buz = n;
        if (bus.active_ch !== prev_ch && !$isunknown(bus.active_ch)) begin
            t_act[bus.active_ch] = n;
            prev_ch = bus.active_ch;
        end
    endtask

    initial begin
        int k;
        int w;

        // Reset
        rst = 1'b0;
        repeat (3) tick();
        check_int("reset_buzzer", int'(bus.buzzer), 0);
        check_int("reset_busy", int'(bus.busy), 0);
        check_int("reset_active_ch", int'(bus.active_ch), 0);
        rst = 1'b1;
        repeat (5) tick();

        // ch0 single pulse; ch2 requested mid-melody queues behind it
        ev_cur[0] = 1'b1; k = n + 1; tick(); ev_cur[0] = 1'b0;
        w = int'($urandom_range(3000, 9000));
        repeat (w) tick();
        ev_cur[2] = 1'b1; tick(); ev_cur[2] = 1'b0;
        repeat (12100 - w) tick();
        check_int("ch0_busy_latency", t_rise - k, 2);
        check_int("ch0_first_toggle", t_buz - t_rise, 1136);
        check_int("ch2_after_ch0", t_act[2] - t_rise, 12001);
        check_int("no_busy_drop", int'(t_fall < t_rise), 1);
        repeat (16100) tick();
        check_int("ch2_length", t_fall - t_act[2], 16000);

        // ch2 pre-empted by ch1 (with simultaneous ch3 edge); ev[1] held high
        ev_cur[2] = 1'b1; tick(); ev_cur[2] = 1'b0;
        repeat (4999) tick();
        ev_cur[1] = 1'b1; ev_cur[3] = 1'b1; k = n + 1; tick(); ev_cur[3] = 1'b0;
        repeat (26300) tick();
        check_int("preempt_latency", t_act[1] - k, 2);
        check_int("ch2_not_resumed", int'(t_act[2] < t_act[1]), 1);
        check_int("ch3_after_ch1", t_act[3] - t_act[1], 14001);
        check_int("ch3_length", t_fall - t_act[3], 12000);
        check_int("held_no_retrigger", int'(t_rise < t_fall), 1);
        ev_cur[1] = 1'b0;
        repeat (10) tick();

        // ch3 with a queued ch2, reset mid-tone
        ev_cur[3] = 1'b1; tick(); ev_cur[3] = 1'b0;
        w = int'($urandom_range(200, 1800));
        for (int i = 0; i < w; i++) begin
`ifdef BUZZER_MUTE_EN
            mute_cur = ($urandom_range(0, 3) == 0);
`endif
            tick();
        end
`ifdef BUZZER_MUTE_EN
        mute_cur = 1'b0;
`endif
        ev_cur[2] = 1'b1; tick(); ev_cur[2] = 1'b0;
        repeat (2) tick();
        check_int("pre_reset_busy", int'(bus.busy), 1);
        rst = 1'b0; tick(); rst = 1'b1;
        check_int("mid_reset_buzzer", int'(bus.buzzer), 0);
        check_int("mid_reset_busy", int'(bus.busy), 0);
        check_int("mid_reset_active_ch", int'(bus.active_ch), 0);
        repeat (200) tick();
        check_int("reset_clears_pend", int'(t_rise < t_fall), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
